// File: rtl/maxpool_stream_kxk_if.sv
// ---------------------------------------------------------------------------
// maxpool_stream_kxk_if
//
// Purpose:
//   Bundles the activation stream going into the KxK pooling engine and the
//   pooled stream coming out of it. Both streams use the same frame/line
//   marker protocol.
//
// Signals:
//   ena             input sample valid; qualifies every *_in flag
//   mode            0 = max, 1 = average (taken on the frame start pixel)
//   frame_start_in  first pixel of a frame (also a line start)
//   line_start_in   first pixel of each line
//   frame_end_in    last pixel of a frame
//   sig_layer       signed input sample
//   valid           max_layer carries a pooled result this cycle
//   max_layer       signed pooled result
//   frame_start_out first valid output of a frame
//   line_start_out  first valid output of each output row
//   frame_end_out   one-cycle end-of-output-frame pulse
//   ovf_err         sticky "line longer than MAX_W" flag
//
// Modports:
//   master  upstream/producer side (drives the input stream, observes results)
//   slave   pooling engine side
// ---------------------------------------------------------------------------
interface maxpool_stream_kxk_if #(
  parameter int DATA_W = 16
) ();

  logic                     ena;
  logic                     mode;
  logic                     frame_start_in;
  logic                     line_start_in;
  logic                     frame_end_in;
  logic signed [DATA_W-1:0] sig_layer;

  logic                     valid;
  logic signed [DATA_W-1:0] max_layer;
  logic                     frame_start_out;
  logic                     line_start_out;
  logic                     frame_end_out;
  logic                     ovf_err;

  modport master (
    output ena, mode, frame_start_in, line_start_in, frame_end_in, sig_layer,
    input  valid, max_layer, frame_start_out, line_start_out, frame_end_out,
           ovf_err
  );

  modport slave (
    input  ena, mode, frame_start_in, line_start_in, frame_end_in, sig_layer,
    output valid, max_layer, frame_start_out, line_start_out, frame_end_out,
           ovf_err
  );

endinterface

// File: rtl/maxpool_stream_kxk.sv
// ---------------------------------------------------------------------------
// maxpool_stream_kxk
//
// Purpose:
//   Streaming KxK pooling engine with stride K. Raster-order activations come
//   in one per enabled cycle; one pooled value leaves per complete KxK
//   window, either the signed maximum or the floor average of the window.
//   Partial windows at the right edge and incomplete row groups at the bottom
//   are silently dropped.
//
// Parameters:
//   DATA_W  signed sample width
//   POOL_K  window size and stride, power of two in 2..8
//   MAX_W   longest supported input line in pixels
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   pool_io  stream interface (slave view), see maxpool_stream_kxk_if
// ---------------------------------------------------------------------------
module maxpool_stream_kxk #(
  parameter int DATA_W = 16,
  parameter int POOL_K = 2,
  parameter int MAX_W  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  maxpool_stream_kxk_if.slave  pool_io
);

  localparam int KLOG  = $clog2(POOL_K);
  // A whole KxK window summed needs 2*KLOG extra bits of headroom.
  localparam int ACC_W = DATA_W + 2 * KLOG;
  localparam int LB_D  = MAX_W / POOL_K;
  localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;
  // col must be able to hold MAX_W itself, where it saturates.
  localparam int COL_W = $clog2(MAX_W + 1);

  localparam logic [KLOG-1:0]  PHASE_LAST = KLOG'(POOL_K - 1);
  localparam logic [COL_W-1:0] COL_LIMIT  = COL_W'(MAX_W);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Combines two partial window results: sum for average, signed max for max.
  function automatic logic signed [ACC_W-1:0] combine(
    input logic                    avg,
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    if (avg) begin
      return a + b;
    end
    return (a > b) ? a : b;
  endfunction

  state_e                   state_q, state_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [KLOG-1:0]          rph_q, rph_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     mode_q, mode_d;
  logic                     ovf_q, ovf_d;
  logic                     first_q, first_d;
  logic [LB_D-1:0]          lb_vld_q, lb_vld_d;

  logic                     valid_q, valid_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic                     fso_q, fso_d;
  logic                     lso_q, lso_d;
  logic                     feo_q, feo_d;

  // Line buffer: one partial column result per output column.
  logic signed [ACC_W-1:0]  lb_q [LB_D];
  logic                     lb_we;
  logic [LB_AW-1:0]         lb_waddr;
  logic signed [ACC_W-1:0]  lb_wdata;

  // Per-pixel working values, all derived in the next-state process.
  logic                     take;
  logic                     mode_eff;
  logic [COL_W-1:0]         col_eff;
  logic [KLOG-1:0]          rph_eff;
  logic [KLOG-1:0]          cph;
  logic [LB_AW-1:0]         wcol;
  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [ACC_W-1:0]  acc_new;
  logic signed [ACC_W-1:0]  merged;
  logic signed [ACC_W-1:0]  avg_shift;

  // Next-state and output logic for every accepted pixel.
  // A frame start is honoured in either state and overrides everything else
  // about the pixel: it restarts the counters, relatches the mode and clears
  // the overflow flag and line buffer valid bits, so an aborted frame cannot
  // leak partial sums into the new one. Pulses default to 0 every cycle, so
  // they clear even during ena gaps, while max_layer holds its value unless a
  // new result or a bare frame-end pulse replaces it.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    rph_d      = rph_q;
    acc_d      = acc_q;
    mode_d     = mode_q;
    ovf_d      = ovf_q;
    first_d    = first_q;
    lb_vld_d   = lb_vld_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    fso_d      = 1'b0;
    lso_d      = 1'b0;
    feo_d      = 1'b0;
    lb_we      = 1'b0;
    lb_waddr   = '0;
    lb_wdata   = '0;
    take       = 1'b0;
    mode_eff   = mode_q;
    col_eff    = col_q;
    rph_eff    = rph_q;
    cph        = '0;
    wcol       = '0;
    sample_ext = {{(2 * KLOG){pool_io.sig_layer[DATA_W-1]}}, pool_io.sig_layer};
    acc_new    = acc_q;
    merged     = acc_q;
    avg_shift  = '0;

    if (pool_io.ena) begin
      if (pool_io.frame_start_in) begin
        take     = 1'b1;
        state_d  = RUN;
        mode_eff = pool_io.mode;
        mode_d   = pool_io.mode;
        col_eff  = '0;
        rph_eff  = '0;
        ovf_d    = 1'b0;
        first_d  = 1'b1;
        lb_vld_d = '0;
      end else if (state_q == RUN) begin
        take = 1'b1;
        if (pool_io.line_start_in) begin
          col_eff = '0;
          rph_eff = (rph_q == PHASE_LAST) ? '0 : rph_q + KLOG'(1);
        end
      end
    end

    if (take) begin
      rph_d = rph_eff;

      if (col_eff >= COL_LIMIT) begin
        // Past the line buffer: drop the pixel and hold col at the limit.
        ovf_d = 1'b1;
        col_d = COL_LIMIT;
      end else begin
        col_d   = col_eff + COL_W'(1);
        cph     = col_eff[KLOG-1:0];
        wcol    = LB_AW'(col_eff >> KLOG);
        acc_new = (cph == '0) ? sample_ext : combine(mode_eff, acc_q, sample_ext);
        acc_d   = acc_new;

        if (cph == PHASE_LAST) begin
          // Top row of a group overwrites; later rows fold into the entry.
          if (rph_eff == '0 || !lb_vld_q[wcol]) begin
            merged = acc_new;
          end else begin
            merged = combine(mode_eff, lb_q[wcol], acc_new);
          end
          lb_we          = 1'b1;
          lb_waddr       = wcol;
          lb_wdata       = merged;
          lb_vld_d[wcol] = 1'b1;

          if (rph_eff == PHASE_LAST) begin
            avg_shift = merged >>> (2 * KLOG);
            valid_d   = 1'b1;
            data_d    = mode_eff ? avg_shift[DATA_W-1:0] : merged[DATA_W-1:0];
            fso_d     = first_d;
            first_d   = 1'b0;
            lso_d     = (wcol == '0);
          end
        end
      end

      if (pool_io.frame_end_in) begin
        state_d = IDLE;
        feo_d   = 1'b1;
        // A frame end that did not close a window reports a zero sample.
        if (!valid_d) begin
          data_d = '0;
        end
      end
    end
  end

  // State, counters and output registers, all cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      col_q    <= '0;
      rph_q    <= '0;
      acc_q    <= '0;
      mode_q   <= 1'b0;
      ovf_q    <= 1'b0;
      first_q  <= 1'b0;
      lb_vld_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      fso_q    <= 1'b0;
      lso_q    <= 1'b0;
      feo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      rph_q    <= rph_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      ovf_q    <= ovf_d;
      first_q  <= first_d;
      lb_vld_q <= lb_vld_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      fso_q    <= fso_d;
      lso_q    <= lso_d;
      feo_q    <= feo_d;
    end
  end

  // Line buffer storage has no reset; the valid bits above decide whether an
  // entry may be folded into.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_waddr] <= lb_wdata;
    end
  end

  assign pool_io.valid           = valid_q;
  assign pool_io.max_layer       = data_q;
  assign pool_io.frame_start_out = fso_q;
  assign pool_io.line_start_out  = lso_q;
  assign pool_io.frame_end_out   = feo_q;
  assign pool_io.ovf_err         = ovf_q;

endmodule

// File: tb/tb_maxpool_stream_kxk.sv
// ---------------------------------------------------------------------------
// tb_maxpool_stream_kxk
//
// Purpose:
//   Directed scoreboard bench for maxpool_stream_kxk with K=2 and MAX_W=8.
//   The driver pushes the hand-computed result of every window-completing
//   pixel, and of every frame end, into a queue together with the cycle in
//   which it must appear; a separate monitor pops an entry whenever the DUT
//   shows valid or any output flag and compares value, flags and timing.
// ---------------------------------------------------------------------------
module tb_maxpool_stream_kxk;

  localparam int DATA_W = 16;
  localparam int POOL_K = 2;
  localparam int MAX_W  = 8;

  typedef struct {
    int                       cyc;
    logic signed [DATA_W-1:0] data;
    bit                       valid;
    bit                       fso;
    bit                       lso;
    bit                       feo;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   lastCyc = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t expQ[$];
  exp_t popped;

  maxpool_stream_kxk_if #(.DATA_W(DATA_W)) pool_if ();

  maxpool_stream_kxk #(
    .DATA_W(DATA_W),
    .POOL_K(POOL_K),
    .MAX_W (MAX_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pool_io(pool_if)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected results.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Presents one pixel for exactly one clock, after an optional ena gap.
  task automatic applyStimulus(input int v, input bit fs, input bit ls, input bit fe,
                               input bit md, input int gap);
    repeat (gap) begin
      @(negedge clk);
      pool_if.ena = 1'b0;
    end
    @(negedge clk);
    pool_if.ena            = 1'b1;
    pool_if.sig_layer      = 16'(v);
    pool_if.frame_start_in = fs;
    pool_if.line_start_in  = ls;
    pool_if.frame_end_in   = fe;
    pool_if.mode           = md;
    @(posedge clk);
    #1;
    lastCyc                = cyc;
    pool_if.ena            = 1'b0;
    pool_if.frame_start_in = 1'b0;
    pool_if.line_start_in  = 1'b0;
    pool_if.frame_end_in   = 1'b0;
  endtask

  // Expected output for the pixel just applied: due in the following cycle.
  task automatic expectOut(input int data, input bit valid, input bit fso,
                           input bit lso, input bit feo);
    exp_t e;
    e.cyc   = lastCyc;
    e.data  = 16'(data);
    e.valid = valid;
    e.fso   = fso;
    e.lso   = lso;
    e.feo   = feo;
    expQ.push_back(e);
  endtask

  // 4x4 frame of 1..16, pixels 1..lastPix. The mode pin is toggled on every
  // pixel except the frame start so a mid-frame mode change would show up.
  task automatic runFrame4x4(input bit md, input int maxGap, input int lastPix);
    int expMax[4];
    int expAvg[4];
    int r, c, idx, gap;
    expMax = '{6, 8, 14, 16};
    expAvg = '{3, 5, 11, 13};
    for (int p = 1; p <= lastPix; p++) begin
      r   = (p - 1) / 4;
      c   = (p - 1) % 4;
      gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      applyStimulus(p, p == 1, c == 0, p == 16, (p == 1) ? md : ~md, gap);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        idx = (r / 2) * 2 + c / 2;
        expectOut(md ? expAvg[idx] : expMax[idx], 1'b1, idx == 0, c == 1, p == 16);
      end
    end
  endtask

  // Single 2x2 window of negatives: -1,-2 / -3,-4.
  task automatic runNeg(input bit md);
    applyStimulus(-1, 1'b1, 1'b1, 1'b0, md, 0);
    applyStimulus(-2, 1'b0, 1'b0, 1'b0, md, 0);
    applyStimulus(-3, 1'b0, 1'b1, 1'b0, md, 0);
    applyStimulus(-4, 1'b0, 1'b0, 1'b1, md, 0);
    expectOut(md ? -3 : -1, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  // Monitor: every output event consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (pool_if.valid || pool_if.frame_start_out ||
                  pool_if.line_start_out || pool_if.frame_end_out)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", longint'(pool_if.max_layer), -9999);
      end else begin
        popped = expQ.pop_front();
        checkOutput("out_cycle", cyc, popped.cyc);
        checkOutput("max_layer", longint'(pool_if.max_layer), longint'(popped.data));
        checkOutput("valid", longint'(pool_if.valid), longint'(popped.valid));
        checkOutput("frame_start_out", longint'(pool_if.frame_start_out), longint'(popped.fso));
        checkOutput("line_start_out", longint'(pool_if.line_start_out), longint'(popped.lso));
        checkOutput("frame_end_out", longint'(pool_if.frame_end_out), longint'(popped.feo));
      end
    end
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    pool_if.ena            = 1'b0;
    pool_if.mode           = 1'b0;
    pool_if.frame_start_in = 1'b0;
    pool_if.line_start_in  = 1'b0;
    pool_if.frame_end_in   = 1'b0;
    pool_if.sig_layer      = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #20;
    checkOutput("rst_valid", longint'(pool_if.valid), 0);
    checkOutput("rst_max_layer", longint'(pool_if.max_layer), 0);
    checkOutput("rst_frame_start_out", longint'(pool_if.frame_start_out), 0);
    checkOutput("rst_line_start_out", longint'(pool_if.line_start_out), 0);
    checkOutput("rst_frame_end_out", longint'(pool_if.frame_end_out), 0);
    checkOutput("rst_ovf_err", longint'(pool_if.ovf_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 4x4 max, then 4x4 average, then negative single windows
    runFrame4x4(1'b0, 0, 16);
    checkOutput("t1_ovf_err", longint'(pool_if.ovf_err), 0);
    runFrame4x4(1'b1, 0, 16);
    runNeg(1'b0);
    runNeg(1'b1);

    // 5x3 frame: only two windows, frame end without a result
    for (int p = 1; p <= 15; p++) begin
      applyStimulus(p, p == 1, (p - 1) % 5 == 0, p == 15, 1'b0, 0);
      if (p == 7)  expectOut(7, 1'b1, 1'b1, 1'b1, 1'b0);
      if (p == 9)  expectOut(9, 1'b1, 1'b0, 1'b0, 1'b0);
      if (p == 15) expectOut(0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Same 4x4 max frame with ena gaps of 0..3 cycles
    runFrame4x4(1'b0, 3, 16);

    // Async reset after pixel 7: the held 6 must vanish at once
    runFrame4x4(1'b0, 0, 7);
    checkOutput("hold_valid", longint'(pool_if.valid), 0);
    checkOutput("hold_max_layer", longint'(pool_if.max_layer), 6);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_valid", longint'(pool_if.valid), 0);
    checkOutput("async_max_layer", longint'(pool_if.max_layer), 0);
    checkOutput("async_frame_start_out", longint'(pool_if.frame_start_out), 0);
    checkOutput("async_line_start_out", longint'(pool_if.line_start_out), 0);
    checkOutput("async_frame_end_out", longint'(pool_if.frame_end_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    runFrame4x4(1'b0, 0, 16);

    // Frame start after pixel 5 aborts; nothing stale may come out
    runFrame4x4(1'b0, 0, 5);
    runFrame4x4(1'b0, 0, 16);

    // 2x10 frame against MAX_W=8: columns 8 and 9 dropped, ovf_err set
    for (int p = 1; p <= 20; p++) begin
      applyStimulus(p, p == 1, (p - 1) % 10 == 0, p == 20, 1'b0, 0);
      if (p == 12) expectOut(12, 1'b1, 1'b1, 1'b1, 1'b0);
      if (p == 14) expectOut(14, 1'b1, 1'b0, 1'b0, 1'b0);
      if (p == 16) expectOut(16, 1'b1, 1'b0, 1'b0, 1'b0);
      if (p == 18) expectOut(18, 1'b1, 1'b0, 1'b0, 1'b0);
      if (p == 20) expectOut(0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("ovf_set", longint'(pool_if.ovf_err), 1);
    applyStimulus(-1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("ovf_cleared", longint'(pool_if.ovf_err), 0);
    applyStimulus(-2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(-3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(-4, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    expectOut(-1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Drain and make sure every expected result appeared
    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
